// File: rtl/fir_word_serializer.sv
// fir_word_serializer
//   Output stage of the FIR datapath. Parallel samples from the FIR core are
//   buffered in a small word FIFO and then shifted out LSB-first as a 1-bit
//   stream, with a valid/ready handshake on every bit.
//
//   Optional feature macro: FIR_SER_PARITY_EN
//     defined   : each word is followed by an even-parity bit (frame = DATA_WIDTH+1)
//     undefined : frame = DATA_WIDTH bits, no parity logic
//
// Ports
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   i_en          global enable; low freezes accept, pop and shift
//   i_din         parallel sample from FIR core
//   i_din_valid   i_din valid
//   o_ready       word FIFO can accept (i_en & ~full)
//   i_ready       downstream ready for a bit
//   o_dout        serial data bit
//   o_dout_valid  o_dout valid
//   o_fifo_count  words currently buffered
//
// state  | meaning
// IDLE   | no word in the shift register; pop as soon as the FIFO is non-empty
// SHIFT  | presenting data bit bit_cnt of the current word
// PARITY | presenting the even-parity bit of the current word (parity builds only)

module fir_word_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_en,
  input  logic [DATA_WIDTH-1:0]                i_din,
  input  logic                                 i_din_valid,
  output logic                                 o_ready,
  input  logic                                 i_ready,
  output logic                                 o_dout,
  output logic                                 o_dout_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH + 1);

`ifdef FIR_SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t                 state, state_nxt;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [BW-1:0]          bit_cnt;
  logic                   push, pop, xfer, last_bit, not_empty;
`ifdef FIR_SER_PARITY_EN
  logic                   par_bit;
`endif

  assign not_empty    = (count != '0);
  assign o_ready      = i_en & (count != CW'(FIFO_DEPTH));
  assign push         = i_din_valid & o_ready;
  assign xfer         = o_dout_valid & i_ready;
  assign last_bit     = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign o_fifo_count = count;

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    o_dout       = 1'b0;
    o_dout_valid = 1'b0;
    case (state)
      IDLE: begin
        if (i_en && not_empty) begin
          pop       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        o_dout       = shreg[0];
        o_dout_valid = i_en;
        if (i_en && i_ready && last_bit) begin
`ifdef FIR_SER_PARITY_EN
          state_nxt = PARITY;
`else
          // Reload straight from the FIFO so consecutive words have no gap.
          if (not_empty) pop = 1'b1;
          else           state_nxt = IDLE;
`endif
        end
      end
`ifdef FIR_SER_PARITY_EN
      PARITY: begin
        o_dout       = par_bit;
        o_dout_valid = i_en;
        if (i_en && i_ready) begin
          if (not_empty) begin
            pop       = 1'b1;
            state_nxt = SHIFT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef FIR_SER_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop) begin
        shreg   <= mem[rd_ptr];
        bit_cnt <= '0;
`ifdef FIR_SER_PARITY_EN
        par_bit <= ^mem[rd_ptr];
`endif
      end else if (state == SHIFT && xfer) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fir_word_serializer.sv
// Testbench for fir_word_serializer: directed scenarios plus a randomized phase,
// all bits checked against a word-level reference model of the serial stream.
module tb_fir_word_serializer;

  localparam int DATA_WIDTH = 24;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
`ifdef FIR_SER_PARITY_EN
  localparam int FRAME = DATA_WIDTH + 1;
`else
  localparam int FRAME = DATA_WIDTH;
`endif

  logic                  tb_clk = 1'b0;
  logic                  i_rst = 1'b1;
  logic                  i_en = 1'b1;
  logic [DATA_WIDTH-1:0] i_din = '0;
  logic                  i_din_valid = 1'b0;
  logic                  o_ready;
  logic                  i_ready = 1'b0;
  logic                  o_dout;
  logic                  o_dout_valid;
  logic [CW-1:0]         o_fifo_count;

  fir_word_serializer #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk        (tb_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_din        (i_din),
    .i_din_valid  (i_din_valid),
    .o_ready      (o_ready),
    .i_ready      (i_ready),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid),
    .o_fifo_count (o_fifo_count)
  );

  always #5 tb_clk = ~tb_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words accepted but not yet fully received, and what came out.
  logic [DATA_WIDTH-1:0] exp_words[$];
  logic [DATA_WIDTH-1:0] rx_words[$];
  logic                  rx_pars[$];
  logic [DATA_WIDTH-1:0] rx_acc = '0;
  int                    rx_pos = 0;
  int                    n_pushed = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor on the falling edge: decides what the coming rising edge transfers.
  always @(negedge tb_clk) begin
    logic [DATA_WIDTH-1:0] w;
    logic                  eb;
    if (i_rst) begin
      exp_words.delete();
      rx_pos = 0;
      rx_acc = '0;
    end else begin
      if (o_dout_valid && i_ready) begin
        if (exp_words.size() == 0) begin
          check_val("extra_bit", 32'(exp_words.size()), 32'd1);
        end else begin
          w  = exp_words[0];
          eb = (rx_pos < DATA_WIDTH) ? w[rx_pos] : ^w;
          check_val("bit", 32'(o_dout), 32'(eb));
          if (rx_pos < DATA_WIDTH) rx_acc[rx_pos] = o_dout;
          rx_pos++;
          if (rx_pos == FRAME) begin
            void'(exp_words.pop_front());
            rx_words.push_back(rx_acc);
            rx_pars.push_back(o_dout);
            rx_pos = 0;
            rx_acc = '0;
          end
        end
      end
      if (i_din_valid && o_ready) begin
        exp_words.push_back(i_din);
        n_pushed++;
      end
    end
  end

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_WIDTH-1:0] w);
    int n = 0;
    bit done = 0;
    i_din       = w;
    i_din_valid = 1'b1;
    while (!done && n < 200) begin
      if (o_ready) done = 1;
      tick();
      n++;
    end
    i_din_valid = 1'b0;
    check_val("push_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((o_dout_valid || o_fifo_count != 0 || exp_words.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check_val(tag, 32'(n < 2000), 32'd1);
  endtask

  task automatic count_run(output int n);
    n = 0;
    while (o_dout_valid && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic check_word(input string tag, input logic [DATA_WIDTH-1:0] exp);
    logic [DATA_WIDTH-1:0] got;
    got = (rx_words.size() != 0) ? rx_words.pop_front() : ~exp;
    check_val(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    int run;
    int xfers;
    logic pv, pd, pr;
    logic [DATA_WIDTH-1:0] t2 [5];

    // Reset state
    i_rst = 1'b1;
    tick(); tick();
    check_val("rst_valid", 32'(o_dout_valid), 32'd0);
    check_val("rst_dout",  32'(o_dout), 32'd0);
    check_val("rst_count", 32'(o_fifo_count), 32'd0);
    check_val("rst_ready", 32'(o_ready), 32'(i_en));
    i_rst = 1'b0;
    tick();

    // 1: single word, latency and LSB-first order
    i_ready = 1'b1;
    rx_words.delete();
    push_word(24'hA5C3F1);
    check_val("t1_count_after_push", 32'(o_fifo_count), 32'd1);
    check_val("t1_valid_latency", 32'(o_dout_valid), 32'd0);
    tick();
    check_val("t1_first_valid", 32'(o_dout_valid), 32'd1);
    check_val("t1_first_bit", 32'(o_dout), 32'd1);
    count_run(run);
    check_val("t1_run_len", 32'(run), 32'(FRAME));
    check_val("t1_valid_after", 32'(o_dout_valid), 32'd0);
    check_val("t1_count_after", 32'(o_fifo_count), 32'd0);
    check_word("t1_word", 24'hA5C3F1);

    // 2: fill the FIFO behind a stalled word, then drain without gaps
    i_ready = 1'b0;
    rx_words.delete();
    t2[0] = 24'h000001; t2[1] = 24'h800000; t2[2] = 24'hFFFFFF;
    t2[3] = 24'h123456; t2[4] = 24'h654321;
    push_word(t2[0]);
    check_val("t2_count0", 32'(o_fifo_count), 32'd1);
    for (int i = 1; i < 5; i++) begin
      push_word(t2[i]);
      check_val("t2_count", 32'(o_fifo_count), 32'(i));
    end
    check_val("t2_full_ready", 32'(o_ready), 32'd0);
    i_ready = 1'b1;
    count_run(run);
    check_val("t2_run_len", 32'(run), 32'(5 * FRAME));
    for (int i = 0; i < 5; i++) check_word("t2_word", t2[i]);

    // 3: i_ready toggling, outputs held while stalled
    i_ready = 1'b0;
    rx_words.delete();
    push_word(24'h5A5A5A);
    tick();
    xfers = 0;
    for (int cyc = 0; cyc < 200 && xfers < FRAME; cyc++) begin
      i_ready = (cyc % 2 == 0);
      pv = o_dout_valid; pd = o_dout; pr = i_ready;
      tick();
      if (pv && pr) xfers++;
      else if (pv) begin
        check_val("t3_stall_dout",  32'(o_dout), 32'(pd));
        check_val("t3_stall_valid", 32'(o_dout_valid), 32'd1);
      end
    end
    i_ready = 1'b1;
    tick();
    check_val("t3_xfers", 32'(xfers), 32'(FRAME));
    check_val("t3_valid_after", 32'(o_dout_valid), 32'd0);
    check_word("t3_word", 24'h5A5A5A);

    // 4: reset mid-word with two words queued
    i_ready = 1'b0;
    rx_words.delete();
    push_word(24'hFFFFFF);
    push_word(24'h111111);
    push_word(24'h222222);
    check_val("t4_queued", 32'(o_fifo_count), 32'd2);
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_val("t4_mid_valid", 32'(o_dout_valid), 32'd1);
    i_rst = 1'b1;
    tick();
    check_val("t4_rst_valid", 32'(o_dout_valid), 32'd0);
    check_val("t4_rst_count", 32'(o_fifo_count), 32'd0);
    i_rst = 1'b0;
    rx_words.delete();
    push_word(24'h00000F);
    wait_idle("t4_idle");
    check_word("t4_word", 24'h00000F);

    // 5: enable dropped mid-word
    i_ready = 1'b1;
    rx_words.delete();
    push_word(24'h3C96E1);
    for (int i = 0; i < 7; i++) tick();
    i_en = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_val("t5_en_valid", 32'(o_dout_valid), 32'd0);
      check_val("t5_en_ready", 32'(o_ready), 32'd0);
      tick();
    end
    i_en = 1'b1;
    wait_idle("t5_idle");
    check_word("t5_word", 24'h3C96E1);

`ifdef FIR_SER_PARITY_EN
    // 6: parity bit
    rx_words.delete();
    rx_pars.delete();
    push_word(24'hA5C3F1);
    push_word(24'h000003);
    wait_idle("t6_idle");
    check_word("t6_word0", 24'hA5C3F1);
    check_word("t6_word1", 24'h000003);
    check_val("t6_par0", 32'(rx_pars.size() > 0 ? rx_pars[0] : 1'bx), 32'd1);
    check_val("t6_par1", 32'(rx_pars.size() > 1 ? rx_pars[1] : 1'bx), 32'd0);
`endif

    // Randomized traffic against the reference model
    rx_words.delete();
    n_pushed = 0;
    for (int i = 0; i < 1500; i++) begin
      i_din       = DATA_WIDTH'($urandom);
      i_din_valid = ($urandom_range(0, 2) == 0);
      i_ready     = ($urandom_range(0, 3) != 0);
      i_en        = ($urandom_range(0, 7) != 0);
      tick();
    end
    i_din_valid = 1'b0;
    i_en        = 1'b1;
    i_ready     = 1'b1;
    wait_idle("rand_idle");
    check_val("rand_words", 32'(rx_words.size()), 32'(n_pushed));
    check_val("rand_left", 32'(exp_words.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
